fp_rslt_buf: RTL and testbench

Result buffer that sits directly downstream of the single-cycle FP execution units (sign-injection, compare, classify, move) and decouples their combinational results from the writeback port. It captures each valid result with its exception flags and destination tag into a small FIFO. It presents entries in order on a valid/ready handshake to the register-file writeback stage, so back-pressure never reaches the execution units' combinational path.

---
 rtl/fp_rslt_buf_pkg.sv | 40 ++++
 rtl/fp_rslt_buf_mem.sv | 33 +++
 rtl/fp_rslt_buf.sv | 133 +++++++++++++
 tb/tb_fp_rslt_buf.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_rslt_buf_pkg.sv
// fp_rslt_buf_pkg
// Shared types and constants for the FP result buffer.
//   fp_rslt_entry_type    : one stored result {result, flags, tag}
//   fp_rslt_buf_in_type   : producer-side bundle (valid + entry)
//   fp_rslt_buf_out_type  : writeback-side bundle (valid + entry)
//   FLAG_* constants      : bit positions inside the 5-bit flag field {NV,DZ,OF,UF,NX}
//   fp_rslt_entry_w()     : packed entry width for a given tag width
package fp_rslt_buf_pkg;

  localparam int FP_RSLT_TAGW = 5;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef struct packed {
    logic [31:0]             result;
    logic [4:0]              flags;
    logic [FP_RSLT_TAGW-1:0] tag;
  } fp_rslt_entry_type;

  typedef struct packed {
    logic              valid;
    fp_rslt_entry_type entry;
  } fp_rslt_buf_in_type;

  typedef struct packed {
    logic              valid;
    fp_rslt_entry_type entry;
  } fp_rslt_buf_out_type;

  // Storage is kept as a flat vector so the tag width can be a parameter
  // of the buffer; layout is {result[31:0], flags[4:0], tag[tagw-1:0]}.
  function automatic int fp_rslt_entry_w(input int tagw);
    return 32 + 5 + tagw;
  endfunction

endpackage

// File: rtl/fp_rslt_buf_mem.sv
// fp_rslt_buf_mem
// DEPTH-entry register array, one synchronous write port, one asynchronous
// read port. Data is not reset; validity is tracked by the owner's counter.
// Ports:
//   clock    : rising-edge clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational)
module fp_rslt_buf_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 42
) (
  input  logic                     clock,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fp_rslt_buf.sv
// fp_rslt_buf
// In-order result FIFO between the single-cycle FP execution units and the
// register-file writeback port. Isolates the execution units from writeback
// back-pressure.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; ready never depends on valid on the same side, and in_ready does not
// look at out_ready (a full buffer refuses input even while it is popping).
//
// Optional feature, macro FP_RSLT_BUF_BYPASS_EN: when the buffer is empty an
// incoming result is presented combinationally on out_*; if the consumer takes
// it in that cycle it is never written. Undefined: out_* come from storage only.
//
// Ports:
//   reset      : asynchronous active-low reset
//   clock      : rising-edge clock
//   flush      : synchronous discard of all entries (push/pop in that cycle ignored)
//   in_valid / in_ready / in_result / in_flags / in_tag : producer side
//   out_valid / out_ready / out_result / out_flags / out_tag : writeback side
//   count      : number of stored entries
module fp_rslt_buf
  import fp_rslt_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
) (
  input  logic                     reset,
  input  logic                     clock,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic [4:0]               in_flags,
  input  logic [TAGW-1:0]          in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [4:0]               out_flags,
  output logic [TAGW-1:0]          out_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = fp_rslt_entry_w(TAGW);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;
  logic [EW-1:0] head;
  logic          empty;
  logic          full;
  logic          byp;
  logic          push;
  logic          pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign wdata = {in_result, in_flags, in_tag};

`ifdef FP_RSLT_BUF_BYPASS_EN
  // Flush wins over bypass so nothing is presented in the flush cycle.
  assign byp = empty && in_valid && !flush;
`else
  assign byp = 1'b0;
`endif

  // A bypassed result taken by the consumer in the same cycle is not stored.
  assign push = in_valid && !full && !flush && !(byp && out_ready);
  assign pop  = !empty && out_ready && !flush;

  always_comb begin
    in_ready   = !full;
    out_valid  = !empty || byp;
    head       = byp ? wdata : rdata;
    out_result = '0;
    out_flags  = '0;
    out_tag    = '0;
    if (out_valid) begin
      {out_result, out_flags, out_tag} = head;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

  fp_rslt_buf_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clock   (clock),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (wdata),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_fp_rslt_buf.sv
// tb_fp_rslt_buf
// Directed bench for fp_rslt_buf (DEPTH=4, TAGW=5). Expected entries are
// queued when a push is driven; a monitor pops and compares on every
// accepted output transfer. Bypass cases are built when
// FP_RSLT_BUF_BYPASS_EN is defined.
module tb_fp_rslt_buf;
  import fp_rslt_buf_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAGW  = 5;
  localparam int W     = 32 + 5 + TAGW;

  logic                   reset;
  logic                   clock;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_result;
  logic [4:0]             in_flags;
  logic [TAGW-1:0]        in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_result;
  logic [4:0]             out_flags;
  logic [TAGW-1:0]        out_tag;
  logic [$clog2(DEPTH):0] count;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  fp_rslt_buf #(
    .DEPTH (DEPTH),
    .TAGW  (TAGW)
  ) dut (
    .reset      (reset),
    .clock      (clock),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_flags   (in_flags),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_tag    (out_tag),
    .count      (count)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one result for the coming edge and record its expectation.
  task automatic drive_push(input logic [31:0] r, input logic [4:0] f, input logic [TAGW-1:0] t);
    in_valid  = 1'b1;
    in_result = r;
    in_flags  = f;
    in_tag    = t;
    exp_q.push_back({r, f, t});
  endtask

  task automatic idle_in();
    in_valid  = 1'b0;
    in_result = '0;
    in_flags  = '0;
    in_tag    = '0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (reset && !flush && out_valid && out_ready) begin
      logic [W-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected: got 0x%0h expected no output", out_result);
      end else begin
        e = exp_q.pop_front();
        if ({out_result, out_flags, out_tag} !== e) begin
          failures++;
          $display("FAIL out_entry: got r=0x%0h f=0x%0h t=%0d expected r=0x%0h f=0x%0h t=%0d",
                   out_result, out_flags, out_tag, e[W-1 -: 32], e[TAGW +: 5], e[TAGW-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle_in();
    tick();
    tick();
    @(negedge clock);
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b1;
    tick();

    // Single push, consumer stalled: visible one cycle later.
    drive_push(32'hBF80_0000, 5'd0, 5'd7);
    tick();
    idle_in();
    @(negedge clock);
    check("single_out_valid", 32'(out_valid), 32'd1);
    check("single_out_result", out_result, 32'hBF80_0000);
    check("single_out_tag", 32'(out_tag), 32'd7);
    check("single_count", 32'(count), 32'd1);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clock);
    check("single_drained", 32'(count), 32'd0);
    tick();

    // Fill to DEPTH, then a fifth request must be refused.
    for (int i = 1; i <= 4; i++) begin
      drive_push(32'(i), 5'(i), 5'(i + 10));
      tick();
    end
    idle_in();
    @(negedge clock);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid  = 1'b1;
    in_result = 32'h5;
    in_flags  = 5'h1f;
    in_tag    = 5'd5;
    tick();
    tick();
    @(negedge clock);
    check("full_reject_count", 32'(count), 32'd4);
    tick();
    idle_in();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b0;
    @(negedge clock);
    check("drain_count", 32'(count), 32'd0);
    tick();

    // Simultaneous push/pop at count=2, then a 10-entry wrap run.
    drive_push(32'h10, 5'b00001, 5'd1);
    tick();
    drive_push(32'h11, 5'b00010, 5'd2);
    tick();
    drive_push(32'h12, 5'b00100, 5'd3);
    out_ready = 1'b1;
    tick();
    idle_in();
    out_ready = 1'b0;
    @(negedge clock);
    check("pushpop_count", 32'(count), 32'd2);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_push(32'h20 + 32'(i), 5'(i), 5'(i + 20));
      tick();
    end
    idle_in();
    @(negedge clock);
    check("wrap_count", 32'(count), 32'd2);
    tick();
    tick();
    out_ready = 1'b0;
    @(negedge clock);
    check("wrap_drained", 32'(count), 32'd0);
    check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // Flush with three stored plus a concurrent push that must vanish.
    for (int i = 0; i < 3; i++) begin
      drive_push(32'h30 + 32'(i), 5'b01000, 5'(i));
      tick();
    end
    idle_in();
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_result = 32'hDEAD_BEEF;
    in_flags  = 5'b11111;
    in_tag    = 5'd31;
    exp_q.delete();
    @(negedge clock);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    tick();
    flush = 1'b0;
    idle_in();
    @(negedge clock);
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    tick();
    drive_push(32'h40, 5'b00001, 5'd9);
    tick();
    idle_in();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clock);
    check("post_flush_count", 32'(count), 32'd0);
    tick();

    // Asynchronous reset in the middle of traffic with three entries held.
    for (int i = 0; i < 3; i++) begin
      drive_push(32'h50 + 32'(i), 5'b00000, 5'(i));
      tick();
    end
    idle_in();
    @(negedge clock);
    check("pre_reset_count", 32'(count), 32'd3);
    tick();
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_result", out_result, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b1;
    tick();

`ifdef FP_RSLT_BUF_BYPASS_EN
    // Empty buffer, consumer ready: zero-latency bypass, nothing stored.
    drive_push(32'h7FC0_0000, 5'b10000, 5'd3);
    out_ready = 1'b1;
    @(negedge clock);
    check("byp_out_valid", 32'(out_valid), 32'd1);
    check("byp_out_result", out_result, 32'h7FC0_0000);
    check("byp_out_flags", 32'(out_flags), 32'(5'b1 << FLAG_NV));
    check("byp_count_same", 32'(count), 32'd0);
    tick();
    idle_in();
    out_ready = 1'b0;
    @(negedge clock);
    check("byp_count_after", 32'(count), 32'd0);
    check("byp_out_valid_after", 32'(out_valid), 32'd0);
    tick();
    // Flush suppresses bypass.
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_result = 32'h1234_5678;
    @(negedge clock);
    check("byp_flush_out_valid", 32'(out_valid), 32'd0);
    tick();
    flush = 1'b0;
    idle_in();
    tick();
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
